// File: rtl/rx_arq_ctrl.sv
// rx_arq_ctrl: receive-side ARQ sequencer (ACK pulse, FIFO flush, retry count, frame drop).
// Optional RECV watchdog is built only when RX_ARQ_TIMEOUT_EN is defined.
module rx_arq_ctrl #(
   parameter int ACK_LEN     = 16,
   parameter int MAX_RETRY   = 3,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_arq_en,
   input  logic       i_frame_start,
   input  logic       i_crc_err,
   input  logic       i_crc_err_valid,
   output logic       o_otn_rx_ack,
   output logic       o_fifo_flush,
   output logic       o_uart_tx_enable,
   output logic [3:0] o_retry_cnt,
   output logic       o_frame_drop,
   output logic       o_busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, ACK = 2'd2, FLUSH = 2'd3} state_t;

   // Handshake: i_frame_start and i_crc_err_valid are single-cycle strobes sampled on the
   // rising edge; there is no back-pressure, a strobe not acted on is simply discarded.
   state_t     state_q, state_d;
   logic       pend_q, pend_d;
   logic [7:0] ack_cnt_q, ack_cnt_d;
   logic       ack_q, ack_d;
   logic       flush_q, flush_d;
   logic       en_q, en_d;
   logic [3:0] retry_q, retry_d;
   logic       drop_q, drop_d;
   logic       busy_q, busy_d;
   logic       err_hit;
   logic       wd_expire;
   logic       retry_room;

   if (ACK_LEN < 2 || ACK_LEN > 255 || MAX_RETRY < 1 || MAX_RETRY > 15 || TIMEOUT_CYC < 1)
   begin : g_bad_params
      $error("rx_arq_ctrl: parameter out of range");
   end

`ifdef RX_ARQ_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   logic [WDW-1:0] wd_q, wd_d;

   assign wd_expire = (state_q == RECV) && (wd_q == WDW'(TIMEOUT_CYC - 1));

   // Counts completed RECV cycles; a lone frame start re-aligns and restarts it.
   always_comb begin
      wd_d = wd_q + 1'b1;
      if (state_q != RECV || (i_frame_start && !i_crc_err_valid)) wd_d = '0;
   end
`else
   assign wd_expire = 1'b0;
`endif

   assign retry_room = ({1'b0, retry_q} + 5'd1) < 5'(MAX_RETRY);

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      ack_cnt_d = ack_cnt_q;
      ack_d     = 1'b0;
      flush_d   = 1'b0;
      drop_d    = 1'b0;
      en_d      = en_q;
      retry_d   = retry_q;
      err_hit   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_frame_start || pend_q) begin
               state_d = RECV;
               pend_d  = 1'b0;
            end
         end
         RECV: begin
            if (i_crc_err_valid) begin
               en_d   = ~i_crc_err;
               pend_d = i_frame_start;
               if (i_crc_err) begin
                  err_hit = 1'b1;
               end else begin
                  retry_d = '0;
                  if (i_arq_en) begin
                     state_d   = ACK;
                     ack_d     = 1'b1;
                     ack_cnt_d = 8'(ACK_LEN - 1);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (i_frame_start) begin
               flush_d = 1'b1;
            end else if (wd_expire) begin
               err_hit = 1'b1;
            end
         end
         ACK: begin
            if (ack_cnt_q == 8'd0) begin
               state_d = (pend_q || i_frame_start) ? RECV : IDLE;
               pend_d  = 1'b0;
            end else begin
               ack_d     = 1'b1;
               ack_cnt_d = ack_cnt_q - 8'd1;
               pend_d    = pend_q | i_frame_start;
            end
         end
         FLUSH: begin
            state_d = (pend_q || i_frame_start) ? RECV : IDLE;
            pend_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      // Error frames (CRC or watchdog) retry only in ARQ mode while budget remains.
      if (err_hit) begin
         state_d = FLUSH;
         flush_d = 1'b1;
         if (i_arq_en && retry_room) begin
            retry_d = retry_q + 4'd1;
         end else begin
            retry_d = '0;
            drop_d  = 1'b1;
         end
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         pend_q    <= 1'b0;
         ack_cnt_q <= '0;
         ack_q     <= 1'b0;
         flush_q   <= 1'b0;
         en_q      <= 1'b0;
         retry_q   <= '0;
         drop_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef RX_ARQ_TIMEOUT_EN
         wd_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         ack_cnt_q <= ack_cnt_d;
         ack_q     <= ack_d;
         flush_q   <= flush_d;
         en_q      <= en_d;
         retry_q   <= retry_d;
         drop_q    <= drop_d;
         busy_q    <= busy_d;
`ifdef RX_ARQ_TIMEOUT_EN
         wd_q      <= wd_d;
`endif
      end
   end

   assign o_otn_rx_ack     = ack_q;
   assign o_fifo_flush     = flush_q;
   assign o_uart_tx_enable = en_q;
   assign o_retry_cnt      = retry_q;
   assign o_frame_drop     = drop_q;
   assign o_busy           = busy_q;

endmodule

// File: tb/tb_rx_arq_ctrl.sv
// tb_rx_arq_ctrl: directed scenarios plus randomized traffic against a cycle-level
// behavioural model of the ARQ controller (define RX_ARQ_TIMEOUT_EN for watchdog builds).
module tb_rx_arq_ctrl;

   localparam int ACK_LEN   = 16;
   localparam int MAX_RETRY = 3;
`ifdef RX_ARQ_TIMEOUT_EN
   localparam int TIMEOUT_CYC = 50;
`else
   localparam int TIMEOUT_CYC = 100000;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       arq_en = 1'b1;
   logic       frame_start = 1'b0;
   logic       crc_err = 1'b0;
   logic       crc_err_valid = 1'b0;
   logic       ack, fifo_flush, uart_en, drop, busy;
   logic [3:0] retry;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_on = 1'b0;

   rx_arq_ctrl #(
      .ACK_LEN(ACK_LEN), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_arq_en(arq_en), .i_frame_start(frame_start),
      .i_crc_err(crc_err), .i_crc_err_valid(crc_err_valid),
      .o_otn_rx_ack(ack), .o_fifo_flush(fifo_flush), .o_uart_tx_enable(uart_en),
      .o_retry_cnt(retry), .o_frame_drop(drop), .o_busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout cycle=%0d actual=running expected=finished", cyc);
      $fatal(1, "simulation time limit");
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // Phases are tracked as "cycles of ACK left", "in RECV", "in flush cycle" rather than states.
   int m_ack_left = 0;
   int m_recv_cyc = 0;
   int m_retry = 0;
   bit m_recv = 0, m_flushing = 0, m_pend = 0, m_en = 0, m_flush = 0, m_drop = 0;
   bit s_f, s_v, s_e, s_a;

   task automatic model_error(input bit a);
      m_flush    = 1;
      m_flushing = 1;
      m_recv     = 0;
      if (a && (m_retry + 1 < MAX_RETRY)) m_retry = m_retry + 1;
      else begin
         m_retry = 0;
         m_drop  = 1;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ack_left = 0; m_recv_cyc = 0; m_retry = 0;
         m_recv = 0; m_flushing = 0; m_pend = 0; m_en = 0; m_flush = 0; m_drop = 0;
      end else begin
         s_f = frame_start; s_v = crc_err_valid; s_e = crc_err; s_a = arq_en;
         m_flush = 0;
         m_drop  = 0;
         if (m_flushing) begin
            m_flushing = 0;
            m_recv     = m_pend || s_f;
            m_pend     = 0;
            m_recv_cyc = 0;
         end else if (m_ack_left > 0) begin
            if (s_f) m_pend = 1;
            m_ack_left = m_ack_left - 1;
            if (m_ack_left == 0) begin
               m_recv     = m_pend;
               m_pend     = 0;
               m_recv_cyc = 0;
            end
         end else if (m_recv) begin
            m_recv_cyc = m_recv_cyc + 1;
            if (s_v) begin
               m_en   = !s_e;
               m_recv = 0;
               if (s_f) m_pend = 1;
               if (s_e) model_error(s_a);
               else begin
                  m_retry = 0;
                  if (s_a) m_ack_left = ACK_LEN;
               end
            end else if (s_f) begin
               m_flush    = 1;
               m_recv_cyc = 0;
            end
`ifdef RX_ARQ_TIMEOUT_EN
            else if (m_recv_cyc == TIMEOUT_CYC) model_error(s_a);
`endif
         end else if (m_pend || s_f) begin
            m_recv     = 1;
            m_pend     = 0;
            m_recv_cyc = 0;
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (chk_on && rst_n === 1'b1) begin
         chk("ack",    32'(ack),        32'(m_ack_left > 0));
         chk("flush",  32'(fifo_flush), 32'(m_flush));
         chk("drop",   32'(drop),       32'(m_drop));
         chk("enable", 32'(uart_en),    32'(m_en));
         chk("retry",  32'(retry),      m_retry);
         chk("busy",   32'(busy),       32'(m_recv || m_flushing || (m_ack_left > 0)));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic f, input logic v, input logic e);
      frame_start = f; crc_err_valid = v; crc_err = e;
      tick();
      frame_start = 0; crc_err_valid = 0; crc_err = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"},   32'(ack),        0);
      chk({tag, "_flush"}, 32'(fifo_flush), 0);
      chk({tag, "_en"},    32'(uart_en),    0);
      chk({tag, "_retry"}, 32'(retry),      0);
      chk({tag, "_drop"},  32'(drop),       0);
      chk({tag, "_busy"},  32'(busy),       0);
   endtask

   int n;
   logic [3:0] exp_retry [3];

   initial begin
      exp_retry[0] = 4'd1; exp_retry[1] = 4'd2; exp_retry[2] = 4'd0;
      #1 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) tick();
      #2 rst_n = 1'b1;
      tick();
      chk_on = 1'b1;
      chk("post_reset_busy", 32'(busy), 0);

      // ARQ pass: ACK for exactly ACK_LEN cycles, then IDLE
      drive(1, 0, 0);
      chk("req019_busy", 32'(busy), 1);
      repeat (19) tick();
      drive(0, 1, 0);
      chk("req019_en", 32'(uart_en), 1);
      chk("req019_retry", 32'(retry), 0);
      n = 0;
      for (int k = 1; k <= 300; k++) begin
         if (ack !== 1'b1) break;
         n++;
         tick();
      end
      chk("req019_ack_len", n, 16);
      chk("req019_idle", 32'(busy), 0);

      // Three consecutive error frames in ARQ mode
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0);
         repeat (3) tick();
         drive(0, 1, 1);
         chk("req020_flush", 32'(fifo_flush), 1);
         chk("req020_retry", 32'(retry), 32'(exp_retry[i]));
         chk("req020_drop", 32'(drop), 32'(i == 2));
         tick();
      end
      chk("req020_en", 32'(uart_en), 0);

      // Non-ARQ mode: error drops immediately, pass returns to IDLE
      arq_en = 1'b0;
      drive(1, 0, 0);
      tick();
      drive(0, 1, 1);
      chk("req021_flush", 32'(fifo_flush), 1);
      chk("req021_drop", 32'(drop), 1);
      chk("req021_ack", 32'(ack), 0);
      tick();
      drive(1, 0, 0);
      tick();
      drive(0, 1, 0);
      chk("req021_idle", 32'(busy), 0);
      chk("req021_en", 32'(uart_en), 1);
      chk("req021_ack2", 32'(ack), 0);
      tick();
      arq_en = 1'b1;

      // Start during ACK cycle 5 is held pending; second start is discarded
      drive(1, 0, 0);
      tick();
      drive(0, 1, 0);
      n = 0;
      for (int k = 1; k <= 300; k++) begin
         if (ack !== 1'b1) break;
         n++;
         frame_start = (k == 5 || k == 7);
         tick();
         frame_start = 1'b0;
      end
      chk("req022_ack_len", n, 16);
      chk("req022_recv", 32'(busy), 1);
      drive(0, 1, 1);
      chk("req022_retry", 32'(retry), 1);
      tick();
      chk("req022_idle", 32'(busy), 0);
      tick();
      chk("req022_no_extra", 32'(busy), 0);

      // Asynchronous reset in ACK cycle 8
      drive(1, 0, 0);
      tick();
      drive(0, 1, 0);
      repeat (7) tick();
      chk("req023_ack_before", 32'(ack), 1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("req023");
      tick();
      #2 rst_n = 1'b1;
      tick();
      chk("req023_idle", 32'(busy), 0);

`ifdef RX_ARQ_TIMEOUT_EN
      drive(1, 0, 0);
      repeat (49) tick();
      chk("req024_no_flush_yet", 32'(fifo_flush), 0);
      tick();
      chk("req024_flush", 32'(fifo_flush), 1);
      chk("req024_retry", 32'(retry), 1);
      tick();
`else
      drive(1, 0, 0);
      repeat (1000) tick();
      chk("req024_still_recv", 32'(busy), 1);
      drive(0, 1, 1);
      chk("req024_flush", 32'(fifo_flush), 1);
      tick();
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (!m_recv && !m_flushing && !m_pend && m_ack_left == 0 && $urandom_range(0, 39) == 0)
            arq_en = ~arq_en;
         frame_start   = ($urandom_range(0, 11) == 0);
         crc_err_valid = ($urandom_range(0, 7) == 0);
         crc_err       = 1'($urandom_range(0, 1));
         if (i == 1500) begin
            #2 rst_n = 1'b0;
            tick();
            #2 rst_n = 1'b1;
         end
         tick();
      end
      frame_start = 0; crc_err_valid = 0; crc_err = 0;
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_arq_ctrl.md
RX_ARQ_CTRL -- requirements
Module: rx_arq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  ACK_LEN, 16, cycles o_otn_rx_ack is held high per ACK (2..255)
  MAX_RETRY, 3, consecutive failed frames before a drop (1..15)
  TIMEOUT_CYC, 100000, RECV watchdog limit in cycles (used only with RX_ARQ_TIMEOUT_EN)
REQ-002 Ports SHALL be, one per line:
  i_clk  in  1  single system clock, rising edge
  i_rst_n  in  1  reset, asynchronous, active-low
  i_arq_en  in  1  ARQ mode enable (board switch, static during a frame)
  i_frame_start  in  1  one-cycle pulse, frame alignment found
  i_crc_err  in  1  CRC result, 1 = error, qualified by i_crc_err_valid
  i_crc_err_valid  in  1  one-cycle pulse, CRC result available
  o_otn_rx_ack  out  1  ACK line to far-end transmitter
  o_fifo_flush  out  1  one-cycle pulse, clear UART TX FIFO
  o_uart_tx_enable  out  1  UART transmitter enable
  o_retry_cnt  out  4  consecutive failed frame count
  o_frame_drop  out  1  one-cycle pulse, frame abandoned
  o_busy  out  1  high in any state except IDLE

Function
REQ-003 FSM states SHALL be IDLE, RECV, ACK, FLUSH; all outputs registered.
REQ-004 IDLE: i_frame_start -> RECV next cycle; i_crc_err_valid ignored.
REQ-005 RECV, i_crc_err_valid=1 and i_crc_err=0: i_arq_en=1 -> ACK; i_arq_en=0 -> IDLE; o_retry_cnt cleared.
REQ-006 RECV, i_crc_err_valid=1 and i_crc_err=1 -> FLUSH.
REQ-007 CRC valid sampled at cycle N SHALL update o_uart_tx_enable at N+1 (1 on pass, 0 on error); otherwise it holds.
REQ-008 ACK: o_otn_rx_ack high for exactly ACK_LEN cycles starting N+1, then -> IDLE, or RECV if pending set.
REQ-009 FLUSH (one cycle): o_fifo_flush high; i_arq_en=1 and o_retry_cnt+1 < MAX_RETRY -> increment, no drop; else o_frame_drop pulses and o_retry_cnt clears; -> IDLE, or RECV if pending set.
REQ-010 i_arq_en=0: error frames always drop (REQ-009 else-branch); o_otn_rx_ack stays 0.
REQ-011 i_frame_start in ACK or FLUSH, or coincident with CRC valid in RECV, SHALL set a one-deep pending flag; extra starts while pending set are discarded.
REQ-012 i_frame_start alone in RECV: o_fifo_flush pulses next cycle, remain RECV, o_retry_cnt unchanged, watchdog restarted.
REQ-013 Any i_crc_err_valid outside RECV SHALL be ignored with no output change.
REQ-014 o_retry_cnt SHALL never exceed MAX_RETRY-1.

Reset
REQ-015 Asserting i_rst_n low SHALL asynchronously force IDLE, clear pending, ACK counter and watchdog, and drive every output to 0.
REQ-016 Reset mid-ACK SHALL drop o_otn_rx_ack immediately; first rising edge after release SHALL see IDLE.

Configuration
REQ-017 Macro RX_ARQ_TIMEOUT_EN defined: watchdog counts RECV cycles from entry; at TIMEOUT_CYC cycles with no CRC valid -> FLUSH as a CRC error (retry/drop per REQ-009).
REQ-018 Macro undefined: no watchdog logic, RECV waits indefinitely, TIMEOUT_CYC ignored.

Verification
REQ-019 ARQ=1, start, CRC pass 20 cycles later -> ack high exactly 16 cycles from N+1, enable=1, retry=0, then IDLE.
REQ-020 ARQ=1, three consecutive CRC-error frames -> flush pulse each; retry 1, 2, then drop pulse, retry=0, enable=0.
REQ-021 ARQ=0, CRC error -> flush and drop pulses at N+1, no ack; CRC pass -> IDLE next cycle, enable=1.
REQ-022 Start pulse in ACK cycle 5 -> ack completes 16 cycles, RECV entered with no extra start; second start discarded.
REQ-023 i_rst_n low in ACK cycle 8 -> all outputs 0 asynchronously, IDLE after release.
REQ-024 RX_ARQ_TIMEOUT_EN, TIMEOUT_CYC=50, start then no CRC -> flush at cycle 51, retry=1; without macro remains RECV beyond 1000 cycles.
